v_upd_ingress: RTL and testbench

V_UPD_INGRESS -- requirements
Module: v_upd_ingress

---
 rtl/v_upd_ingress.sv | 132 +++++++++++++
 tb/tb_v_upd_ingress.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/v_upd_ingress.sv
// Update ingress: buffers producer updates in a small FIFO and issues them in order.
// An update is held at the head while its key matches any issue in the last HAZ_WIN cycles.
package v_pkg;
    typedef logic [3:0]  id_t;
    typedef logic [1:0]  cmd_t;
    typedef logic [7:0]  key_t;
    typedef logic [11:0] size_t;
endpackage

module v_upd_ingress
    import v_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HAZ_WIN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_upd_vld,
    input  id_t         i_upd_prod_id,
    input  cmd_t        i_upd_cmd,
    input  key_t        i_upd_key,
    input  size_t       i_upd_size,
    output logic        o_upd_rdy,
    output logic        o_upd_vld_r,
    output id_t         o_upd_prod_id_r,
    output cmd_t        o_upd_cmd_r,
    output key_t        o_upd_key_r,
    output size_t       o_upd_size_r,
    output logic        o_empty,
    output logic [15:0] o_stall_cnt_r
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

    upd_t              mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [HAZ_WIN-1:0] hist_vld_q;
    key_t              hist_key_q [HAZ_WIN];
    logic [15:0]       stall_cnt_d;

    upd_t head;
    logic full, empty, push, pop, hazard;

    // Pointer-derived status; the extra MSB separates full from empty.
    always_comb begin
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        o_upd_rdy = !full;
        o_empty   = empty;
        push      = i_upd_vld && !full;
        head      = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Head is blocked if its key was issued in any of the tracked recent slots.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (hist_vld_q[i] && (hist_key_q[i] == head.key)) hazard = 1'b1;
        end
        pop = !empty && !hazard;
    end

    // Next-state for pointers and the saturating stall counter.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        stall_cnt_d = o_stall_cnt_r;
        if (!empty && hazard && (o_stall_cnt_r != 16'hFFFF)) stall_cnt_d = o_stall_cnt_r + 16'd1;
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{i_upd_prod_id, i_upd_cmd, i_upd_key, i_upd_size};
    end

    // Pointers and stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            o_stall_cnt_r <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            o_stall_cnt_r <= stall_cnt_d;
        end
    end

    // Issue history: slot 0 mirrors the output register, older slots shift each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_vld_q <= '0;
            for (int i = 0; i < HAZ_WIN; i++) hist_key_q[i] <= '0;
        end else begin
            hist_vld_q[0] <= pop;
            hist_key_q[0] <= head.key;
            for (int i = 1; i < HAZ_WIN; i++) begin
                hist_vld_q[i] <= hist_vld_q[i-1];
                hist_key_q[i] <= hist_key_q[i-1];
            end
        end
    end

    // Registered issue bus; data holds its last issued value while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= '0;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
        end else begin
            o_upd_vld_r <= pop;
            if (pop) begin
                o_upd_prod_id_r <= head.prod_id;
                o_upd_cmd_r     <= head.cmd;
                o_upd_key_r     <= head.key;
                o_upd_size_r    <= head.size;
            end
        end
    end

endmodule

// File: tb/tb_v_upd_ingress.sv
// Directed bench for v_upd_ingress: per-cycle expected issue/ready tables, hand-derived.
module tb_v_upd_ingress;
    import v_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_upd_vld;
    id_t         i_upd_prod_id;
    cmd_t        i_upd_cmd;
    key_t        i_upd_key;
    size_t       i_upd_size;
    logic        o_upd_rdy;
    logic        o_upd_vld_r;
    id_t         o_upd_prod_id_r;
    cmd_t        o_upd_cmd_r;
    key_t        o_upd_key_r;
    size_t       o_upd_size_r;
    logic        o_empty;
    logic [15:0] o_stall_cnt_r;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    v_upd_ingress #(.DEPTH(4), .HAZ_WIN(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_upd_vld      (i_upd_vld),
        .i_upd_prod_id  (i_upd_prod_id),
        .i_upd_cmd      (i_upd_cmd),
        .i_upd_key      (i_upd_key),
        .i_upd_size     (i_upd_size),
        .o_upd_rdy      (o_upd_rdy),
        .o_upd_vld_r    (o_upd_vld_r),
        .o_upd_prod_id_r(o_upd_prod_id_r),
        .o_upd_cmd_r    (o_upd_cmd_r),
        .o_upd_key_r    (o_upd_key_r),
        .o_upd_size_r   (o_upd_size_r),
        .o_empty        (o_empty),
        .o_stall_cnt_r  (o_stall_cnt_r)
    );

    // Side fields are derived from the key so every issued field can be predicted.
    function automatic id_t f_id(input key_t k);
        return id_t'(k[3:0] ^ 4'hA);
    endfunction
    function automatic cmd_t f_cmd(input key_t k);
        return cmd_t'(k[5:4]);
    endfunction
    function automatic size_t f_size(input key_t k);
        return size_t'({k, 4'h3});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Check this cycle's outputs, then drive this cycle's inputs and advance.
    task automatic tick(input bit v, input key_t k, input bit ev, input key_t ek, input bit erdy);
        chk("upd_vld_r", {31'd0, o_upd_vld_r}, {31'd0, ev});
        if (ev) begin
            chk("upd_key_r",  {24'd0, o_upd_key_r},     {24'd0, ek});
            chk("upd_id_r",   {28'd0, o_upd_prod_id_r}, {28'd0, f_id(ek)});
            chk("upd_cmd_r",  {30'd0, o_upd_cmd_r},     {30'd0, f_cmd(ek)});
            chk("upd_size_r", {20'd0, o_upd_size_r},    {20'd0, f_size(ek)});
        end
        chk("upd_rdy", {31'd0, o_upd_rdy}, {31'd0, erdy});
        i_upd_vld     = v;
        i_upd_key     = k;
        i_upd_prod_id = f_id(k);
        i_upd_cmd     = f_cmd(k);
        i_upd_size    = f_size(k);
        step();
    endtask

    // Assert reset mid-cycle, check outputs while held, release just after an edge.
    task automatic do_reset();
        i_upd_vld = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_vld_r", {31'd0, o_upd_vld_r}, 32'd0);
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        chk("rst_rdy",   {31'd0, o_upd_rdy}, 32'd1);
        chk("rst_stall", {16'd0, o_stall_cnt_r}, 32'd0);
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        i_upd_vld = 1'b0;
        i_upd_key = '0;
        i_upd_prod_id = '0;
        i_upd_cmd = '0;
        i_upd_size = '0;
        step();
        step();
        chk("init_vld_r", {31'd0, o_upd_vld_r}, 32'd0);
        chk("init_key_r", {24'd0, o_upd_key_r}, 32'd0);
        chk("init_id_r",  {28'd0, o_upd_prod_id_r}, 32'd0);
        chk("init_size_r", {20'd0, o_upd_size_r}, 32'd0);
        chk("init_empty", {31'd0, o_empty}, 32'd1);
        chk("init_rdy",   {31'd0, o_upd_rdy}, 32'd1);
        chk("init_stall", {16'd0, o_stall_cnt_r}, 32'd0);
        rst = 1'b1;

        // Single update: issues two cycles after accept, FIFO empty from then.
        tick(1, 8'd5, 0, 8'd0, 1);
        chk("t1_empty_c1", {31'd0, o_empty}, 32'd0);
        tick(0, 8'd0, 0, 8'd0, 1);
        chk("t1_empty_c2", {31'd0, o_empty}, 32'd1);
        tick(0, 8'd0, 1, 8'd5, 1);
        tick(0, 8'd0, 0, 8'd0, 1);

        // Distinct keys stream back-to-back with no stalls.
        do_reset();
        tick(1, 8'd1, 0, 8'd0, 1);
        tick(1, 8'd2, 0, 8'd0, 1);
        tick(1, 8'd3, 1, 8'd1, 1);
        tick(1, 8'd4, 1, 8'd2, 1);
        tick(0, 8'd0, 1, 8'd3, 1);
        tick(0, 8'd0, 1, 8'd4, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        chk("t2_stall", {16'd0, o_stall_cnt_r}, 32'd0);

        // Same key twice: second issue held HAZ_WIN cycles.
        do_reset();
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(0, 8'd0, 1, 8'd7, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 1, 8'd7, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        chk("t3_stall", {16'd0, o_stall_cnt_r}, 32'd3);

        // Head-of-line: key 8 waits behind the stalled second key 7.
        do_reset();
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(1, 8'd8, 1, 8'd7, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 1, 8'd7, 1);
        tick(0, 8'd0, 1, 8'd8, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        chk("t4_stall", {16'd0, o_stall_cnt_r}, 32'd3);

        // Fill to full behind a blocked head; held update 4 accepted once space frees.
        do_reset();
        tick(1, 8'd9, 0, 8'd0, 1);
        tick(1, 8'd9, 0, 8'd0, 1);
        tick(1, 8'd1, 1, 8'd9, 1);
        tick(1, 8'd2, 0, 8'd0, 1);
        tick(1, 8'd3, 0, 8'd0, 1);
        tick(1, 8'd4, 0, 8'd0, 0);
        tick(1, 8'd4, 1, 8'd9, 1);
        tick(1, 8'd5, 1, 8'd1, 1);
        tick(0, 8'd0, 1, 8'd2, 1);
        tick(0, 8'd0, 1, 8'd3, 1);
        tick(0, 8'd0, 1, 8'd4, 1);
        tick(0, 8'd0, 1, 8'd5, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        chk("t5_empty", {31'd0, o_empty}, 32'd1);
        chk("t5_stall", {16'd0, o_stall_cnt_r}, 32'd3);

        // Reset while stalled with three entries queued.
        do_reset();
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(1, 8'd1, 1, 8'd7, 1);
        tick(1, 8'd2, 0, 8'd0, 1);
        i_upd_vld = 1'b0;
        chk("t6_stall_pre", {16'd0, o_stall_cnt_r}, 32'd2);
        chk("t6_empty_pre", {31'd0, o_empty}, 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("t6_empty_post", {31'd0, o_empty}, 32'd1);
            tick(0, 8'd0, 0, 8'd0, 1);
        end
        tick(1, 8'd7, 0, 8'd0, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        tick(0, 8'd0, 1, 8'd7, 1);
        chk("t6_stall_post", {16'd0, o_stall_cnt_r}, 32'd0);

        // Ten distinct keys: pointers wrap past 2*DEPTH.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1, key_t'(20 + i), (i >= 2), key_t'(18 + i), 1);
        end
        tick(0, 8'd0, 1, 8'd28, 1);
        tick(0, 8'd0, 1, 8'd29, 1);
        tick(0, 8'd0, 0, 8'd0, 1);
        chk("t7_empty", {31'd0, o_empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
